// File: rtl/timer_irq_source.sv
// Memory-mapped countdown timer that raises one CP0 hardware-interrupt line.
// CTRL/PRESET are software-writable, COUNT is read-only, IRQ = pend & CTRL.IM.
module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    logic [3:0]  ctrl_r, ctrl_nxt_s;
    logic [31:0] preset_r, preset_nxt_s;
    logic [31:0] count_r, count_nxt_s;
    logic [1:0]  state_r, state_nxt_s;
    logic        pend_r, pend_nxt_s;
    logic        irq_r;
    logic        hit_s, wr_ctrl_s, wr_preset_s, reload_s;
    logic        unused_s;

    assign hit_s       = (Addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl_s   = WE & hit_s & (Addr[3:2] == REG_CTRL);
    assign wr_preset_s = WE & hit_s & (Addr[3:2] == REG_PRESET);
    // MODE 1x behaves as one-shot, so only 01 reloads
    assign reload_s    = (ctrl_r[2:1] == 2'b01);
    assign unused_s    = ^{Addr[1:0], DIn[31:4]};

    // Next-state: FSM first, then the bus write overrides CTRL and acknowledges pend
    always_comb begin
        ctrl_nxt_s   = ctrl_r;
        preset_nxt_s = preset_r;
        count_nxt_s  = count_r;
        state_nxt_s  = state_r;
        pend_nxt_s   = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[0]) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nxt_s = preset_r;
                state_nxt_s = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_r[0]) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r > 32'd1) begin
                    count_nxt_s = count_r - 32'd1;
                end else begin
                    count_nxt_s = 32'd0;
                    pend_nxt_s  = 1'b1;
                    state_nxt_s = ST_INT;
                end
            end
            ST_INT: begin
                if (reload_s) begin
                    pend_nxt_s  = 1'b0;
                    state_nxt_s = ST_LOAD;
                end else begin
                    ctrl_nxt_s[0] = 1'b0;
                    state_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (wr_ctrl_s) begin
            ctrl_nxt_s = DIn[3:0];
            pend_nxt_s = 1'b0;
        end else begin
            ctrl_nxt_s = ctrl_nxt_s;
        end
        if (wr_preset_s) begin
            preset_nxt_s = DIn;
        end else begin
            preset_nxt_s = preset_nxt_s;
        end
    end

    // State registers; IRQ is registered from the next-state so it tracks pend without a lag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r   <= 4'h0;
            preset_r <= 32'h0;
            count_r  <= 32'h0;
            state_r  <= ST_IDLE;
            pend_r   <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            ctrl_r   <= ctrl_nxt_s;
            preset_r <= preset_nxt_s;
            count_r  <= count_nxt_s;
            state_r  <= state_nxt_s;
            pend_r   <= pend_nxt_s;
            irq_r    <= pend_nxt_s & ctrl_nxt_s[3];
        end
    end

    // Zero-latency read mux
    always_comb begin
        DOut = 32'h0;
        if (hit_s) begin
            case (Addr[3:2])
                REG_CTRL:   DOut = {28'h0, ctrl_r};
                REG_PRESET: DOut = preset_r;
                REG_COUNT:  DOut = count_r;
                default:    DOut = 32'h0;
            endcase
        end else begin
            DOut = 32'h0;
        end
    end

    assign IRQ = irq_r;

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench for timer_irq_source; expected values worked out by hand from edge counts.
module tb_timer_irq_source;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;
    localparam logic [31:0] A_OUT    = 32'h0000_7F14;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int total;
    int passed;

    timer_irq_source dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called just after a rising edge; the write lands on the next edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Addr = 32'h0;
        DIn  = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        Addr = a;
        #1;
        chk(tag, DOut, exp);
        Addr = 32'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'h0, IRQ}, {31'h0, exp});
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        WE     = 1'b0;
        Addr   = 32'h0;
        DIn    = 32'h0;
        tick(2);
        reset = 1'b1;
        tick(1);

        // reset state and read-only / reserved / out-of-block behaviour
        rd(A_CTRL,   32'h0, "rst_ctrl");
        rd(A_PRESET, 32'h0, "rst_preset");
        rd(A_COUNT,  32'h0, "rst_count");
        rd(A_RSVD,   32'h0, "rst_rsvd");
        chk_irq("rst_irq", 1'b0);
        wr(A_COUNT, 32'hFFFF_FFFF);
        rd(A_COUNT, 32'h0, "count_ro");
        wr(A_RSVD, 32'hFFFF_FFFF);
        rd(A_RSVD, 32'h0, "rsvd_ro");
        wr(A_OUT, 32'h1234_5678);
        rd(A_PRESET, 32'h0, "out_wr_ignored");
        wr(A_PRESET, 32'hDEAD_BEEF);
        rd(A_PRESET, 32'hDEAD_BEEF, "preset_rw");
        rd(A_OUT, 32'h0, "out_rd_zero");
        wr(A_CTRL, 32'hFFFF_FFF0);
        rd(A_CTRL, 32'h0, "ctrl_upper_ignored");

        // one-shot, PRESET=5: COUNT=5 after edge 2, 1 after edge 6, IRQ after edge 7
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        tick(2);
        rd(A_COUNT, 32'd5, "os_count_e2");
        tick(4);
        rd(A_COUNT, 32'd1, "os_count_e6");
        chk_irq("os_irq_e6", 1'b0);
        tick(1);
        chk_irq("os_irq_e7", 1'b1);
        tick(1);
        rd(A_CTRL, 32'h8, "os_en_cleared");
        tick(3);
        chk_irq("os_irq_holds", 1'b1);
        wr(A_CTRL, 32'h8);
        chk_irq("os_ack", 1'b0);

        // auto-reload, PRESET=3: one-cycle pulses at edges 5,10,15,20
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk_irq($sformatf("ar_irq_e%0d", k), (k % 5) == 0);
        end
        rd(A_CTRL, 32'hB, "ar_en_stays");
        wr(A_CTRL, 32'h8);
        tick(3);

        // PRESET=0 fires after edge 3
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h9);
        tick(2);
        chk_irq("p0_irq_e2", 1'b0);
        tick(1);
        chk_irq("p0_irq_e3", 1'b1);
        wr(A_CTRL, 32'h8);
        chk_irq("p0_ack", 1'b0);

        // same with IM=0: expires silently and EN clears
        wr(A_CTRL, 32'h1);
        tick(3);
        chk_irq("im0_irq_e3", 1'b0);
        rd(A_COUNT, 32'd0, "im0_count");
        tick(1);
        rd(A_CTRL, 32'h0, "im0_en_cleared");
        chk_irq("im0_irq_e4", 1'b0);

        // CTRL write in INT beats the FSM's EN clear; timer runs again
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h9);
        tick(3);
        chk_irq("race_irq_e3", 1'b1);
        wr(A_CTRL, 32'h9);
        rd(A_CTRL, 32'h9, "race_ctrl_kept");
        chk_irq("race_acked", 1'b0);
        tick(3);
        chk_irq("race_refire", 1'b1);
        wr(A_CTRL, 32'h8);

        // pause at COUNT=7, then re-enable reloads PRESET; PRESET write mid-count is deferred
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        tick(5);
        rd(A_COUNT, 32'd7, "pause_count7");
        wr(A_CTRL, 32'h8);
        tick(3);
        rd(A_COUNT, 32'd6, "pause_frozen");
        chk_irq("pause_no_irq", 1'b0);
        wr(A_CTRL, 32'h9);
        tick(2);
        rd(A_COUNT, 32'd10, "reen_reload");
        wr(A_PRESET, 32'd2);
        rd(A_COUNT, 32'd9, "preset_deferred");
        tick(8);
        chk_irq("reen_irq_e11", 1'b0);
        tick(1);
        chk_irq("reen_irq_e12", 1'b1);

        // async reset with IRQ high drops it before the next edge
        reset = 1'b0;
        #1;
        chk_irq("areset_irq_drop", 1'b0);
        rd(A_CTRL, 32'h0, "areset_ctrl");
        reset = 1'b1;
        tick(1);

        // reset mid-count in auto-reload at COUNT=4
        wr(A_PRESET, 32'd6);
        wr(A_CTRL, 32'hB);
        tick(4);
        rd(A_COUNT, 32'd4, "mid_count4");
        reset = 1'b0;
        #1;
        chk_irq("mid_irq", 1'b0);
        rd(A_CTRL,   32'h0, "mid_ctrl");
        rd(A_PRESET, 32'h0, "mid_preset");
        rd(A_COUNT,  32'h0, "mid_count");
        reset = 1'b1;
        tick(4);
        rd(A_CTRL,  32'h0, "post_ctrl");
        rd(A_COUNT, 32'h0, "post_count");
        chk_irq("post_irq", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
